// File: rtl/layer_bram_arbiter.sv
// Single-port controller for the 320x240 3-bit layer frame buffer.
// One BRAM port shared by display read-out, frame clear and draw writes.
module layer_bram_arbiter #(
    parameter int NUM_PIX = 76800,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              err_clr,
    output logic              err_oob,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(NUM_PIX);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_PIX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_col_q, clr_col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              err_q, err_d;
    logic              rd1_q, rd1_oob_q;
    logic              rd2_q, rd2_oob_q;
    logic              dv_q;
    logic [DATA_W-1:0] dd_q;
    logic              wr_oob, disp_oob, wr_fire;

    assign wr_oob   = {1'b0, wr_addr} >= LIMIT;
    assign disp_oob = {1'b0, disp_addr} >= LIMIT;
    assign wr_ready = !disp_req && (state_q == IDLE);
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_col_d = clr_col_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        din_d     = din_q;
        err_d     = err_q;
        if (err_clr) err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    clr_col_d = clr_color;
                end
                if (wr_fire) begin
                    addr_d = wr_addr;
                    din_d  = wr_data;
                    we_d   = !wr_oob;
                    // a dropped write beats a simultaneous clear request
                    if (wr_oob) err_d = 1'b1;
                end
            end
            CLEAR: begin
                if (!disp_req) begin
                    addr_d    = clr_cnt_q;
                    din_d     = clr_col_q;
                    we_d      = 1'b1;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == LAST) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // display owns the port unconditionally
        if (disp_req) begin
            addr_d = disp_addr;
            we_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            clr_col_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            din_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            clr_col_q <= clr_col_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            din_q     <= din_d;
            err_q     <= err_d;
        end
    end

    // read return: address out, BRAM register, then output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q     <= 1'b0;
            rd1_oob_q <= 1'b0;
            rd2_q     <= 1'b0;
            rd2_oob_q <= 1'b0;
            dv_q      <= 1'b0;
            dd_q      <= '0;
        end else begin
            rd1_q     <= disp_req;
            rd1_oob_q <= disp_oob;
            rd2_q     <= rd1_q;
            rd2_oob_q <= rd1_oob_q;
            dv_q      <= rd2_q;
            if (rd2_q) dd_q <= rd2_oob_q ? '0 : mem_dout;
        end
    end

    assign disp_valid = dv_q;
    assign disp_data  = dd_q;
    assign clr_busy   = (state_q == CLEAR);
    assign clr_done   = (state_q == DONE);
    assign err_oob    = err_q;
    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_din    = din_q;

endmodule

// File: tb/tb_layer_bram_arbiter.sv
// Bench for layer_bram_arbiter: random and directed traffic against a
// frame-level model of port ownership, clear progress and pixel contents.
module tb_layer_bram_arbiter;
    localparam int NP = 16;
    localparam int AW = 5;
    localparam int DW = 3;

    typedef struct { int c; int a; int d; } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          clr_done;
    logic          err_clr = 1'b0;
    logic          err_oob;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    logic [DW-1:0] bram [32] = '{16: 3'b101, 20: 3'b111, default: 3'b000};
    int rm [32] = '{default: 0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ev_t wlog[$], dlog[$], exp_w[$], exp_d[$];
    int donelog[$], exp_done[$];
    bit m_busy = 0, m_err = 0, m_rdy = 0, obs_rdy = 0;
    int m_next = 0, m_col = 0, m_done_c = -10;

    layer_bram_arbiter #(.NUM_PIX(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .err_clr(err_clr), .err_oob(err_oob),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // BRAM model (read-first, 1-cycle latency) plus event logs
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) wlog.push_back('{cyc, int'(mem_addr), int'(mem_din)});
        if (disp_valid) dlog.push_back('{cyc, 0, int'(disp_data)});
        if (clr_done) donelog.push_back(cyc);
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    // drive one cycle and predict its effect from the ownership rules
    task automatic tick(input bit rq, input int ra, input bit wv,
                        input int wa, input int wd, input bit cs,
                        input int cc, input bit ec);
        int c;
        bit idle;
        disp_req  = rq;
        disp_addr = AW'(ra);
        wr_valid  = wv;
        wr_addr   = AW'(wa);
        wr_data   = DW'(wd);
        clr_start = cs;
        clr_color = DW'(cc);
        err_clr   = ec;
        c = cyc;
        idle = !m_busy && (c != m_done_c + 1);
        m_rdy = !rq && idle;
        if (rq) begin
            exp_d.push_back('{c + 3, 0, (ra < NP) ? rm[ra] : 0});
        end else if (m_busy) begin
            exp_w.push_back('{c + 1, m_next, m_col});
            rm[m_next] = m_col;
            m_next++;
            if (m_next == NP) begin
                m_busy = 0;
                m_done_c = c;
                exp_done.push_back(c + 1);
            end
        end else if (idle && wv && wa < NP) begin
            exp_w.push_back('{c + 1, wa, wd});
            rm[wa] = wd;
        end
        if (m_rdy && wv && wa >= NP) m_err = 1;
        else if (ec) m_err = 0;
        if (idle && cs) begin
            m_busy = 1;
            m_next = 0;
            m_col = cc;
        end
        #1;
        obs_rdy = wr_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        repeat (4) tick(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wlog.size() != exp_w.size()) begin
            errors++;
            $display("FAIL %s write count got %0d want %0d", nm, wlog.size(), exp_w.size());
        end else begin
            foreach (wlog[i]) begin
                checks++;
                if (wlog[i].c != exp_w[i].c || wlog[i].a != exp_w[i].a || wlog[i].d != exp_w[i].d) begin
                    errors++;
                    $display("FAIL %s write %0d got c%0d a%0d d%0d want c%0d a%0d d%0d", nm, i,
                             wlog[i].c, wlog[i].a, wlog[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
                end
            end
        end
        checks++;
        if (dlog.size() != exp_d.size()) begin
            errors++;
            $display("FAIL %s read count got %0d want %0d", nm, dlog.size(), exp_d.size());
        end else begin
            foreach (dlog[i]) begin
                checks++;
                if (dlog[i].c != exp_d[i].c || dlog[i].d != exp_d[i].d) begin
                    errors++;
                    $display("FAIL %s read %0d got c%0d d%0d want c%0d d%0d", nm, i,
                             dlog[i].c, dlog[i].d, exp_d[i].c, exp_d[i].d);
                end
            end
        end
        checks++;
        if (donelog != exp_done) begin
            errors++;
            $display("FAIL %s clr_done pulses got %p want %p", nm, donelog, exp_done);
        end
        wlog.delete(); dlog.delete(); donelog.delete();
        exp_w.delete(); exp_d.delete(); exp_done.delete();
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({mem_addr, mem_we, mem_din, disp_valid, disp_data, clr_busy, clr_done, err_oob} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {mem_addr, mem_we, mem_din, disp_valid, disp_data, clr_busy, clr_done, err_oob});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready got %b want 1", obs_rdy);
        end
        drain("reset");
    endtask

    task automatic test_write_read;
        tick(0, 0, 1, 5, 2, 0, 0, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 5'd5 || mem_din !== 3'b010) begin
            errors++;
            $display("FAIL wr_issue got we%b a%0d d%0d want we1 a5 d2", mem_we, mem_addr, mem_din);
        end
        tick(1, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 5'd5) begin
            errors++;
            $display("FAIL rd_issue got we%b a%0d want we0 a5", mem_we, mem_addr);
        end
        tick(1, 20, 0, 0, 0, 0, 0, 0);
        tick(1, NP, 0, 0, 0, 0, 0, 0);
        drain("write_read");
    endtask

    task automatic test_disp_block;
        int wa, wd;
        wa = $urandom_range(0, NP - 1);
        wd = $urandom_range(0, 7);
        repeat (4) begin
            tick(1, $urandom_range(0, NP - 1), 1, wa, wd, 0, 0, 0);
            checks++;
            if (obs_rdy !== m_rdy || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL block got rdy%b we%b want rdy%b we0", obs_rdy, mem_we, m_rdy);
            end
        end
        tick(0, 0, 1, wa, wd, 0, 0, 0);
        checks++;
        if (obs_rdy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(wa)) begin
            errors++;
            $display("FAIL unblock got rdy%b we%b a%0d want rdy1 we1 a%0d", obs_rdy, mem_we, mem_addr, wa);
        end
        drain("disp_block");
    endtask

    task automatic test_clear;
        int n = 0;
        tick(0, 0, 0, 0, 0, 1, 4, 0);
        while (n < 40 && (m_busy || n < 20)) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (clr_busy !== m_busy || clr_done !== (m_done_c == cyc - 1)) begin
                errors++;
                $display("FAIL clear_flags got busy%b done%b want busy%b done%b",
                         clr_busy, clr_done, m_busy, m_done_c == cyc - 1);
            end
            n++;
        end
        for (int i = 0; i < NP; i++) tick(1, i, 0, 0, 0, 0, 0, 0);
        drain("clear");
    endtask

    task automatic test_clear_disp;
        int i = 0;
        tick(0, 0, 0, 0, 0, 1, 3, 0);
        while (m_busy && i < 100) begin
            tick(i % 3 == 0, $urandom_range(0, NP - 1), 0, 0, 0, 0, 0, 0);
            checks++;
            if (clr_busy !== m_busy) begin
                errors++;
                $display("FAIL clear_disp_busy got %b want %b", clr_busy, m_busy);
            end
            i++;
        end
        drain("clear_disp");
    endtask

    task automatic test_oob;
        tick(0, 0, 1, NP, 5, 0, 0, 0);
        checks++;
        if (obs_rdy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(NP) || err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_write got rdy%b we%b a%0d err%b want rdy1 we0 a%0d err1",
                     obs_rdy, mem_we, mem_addr, err_oob, NP);
        end
        repeat (2) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (err_oob !== m_err) begin
                errors++;
                $display("FAIL oob_sticky got %b want %b", err_oob, m_err);
            end
        end
        tick(0, 0, 1, NP + 2, 1, 0, 0, 1);
        checks++;
        if (err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_set_wins got %b want 1", err_oob);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (err_oob !== m_err) begin
            errors++;
            $display("FAIL oob_clear got %b want %b", err_oob, m_err);
        end
        drain("oob");
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        int saved;
        tick(0, 0, 0, 0, 0, 1, 2, 0);
        while (m_next < 7 && n < 20) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        saved = rm[7];
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_addr !== 5'd7 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got a%0d we%b want a7 we1", mem_addr, mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_we, mem_din, disp_valid, disp_data, clr_busy, clr_done, err_oob} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h want 0",
                     {mem_addr, mem_we, mem_din, disp_valid, disp_data, clr_busy, clr_done, err_oob});
        end
        void'(exp_w.pop_back());
        rm[7] = saved;
        m_busy = 0;
        m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0, 1, 6, 0);
        n = 0;
        while (m_busy && n < 40) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        drain("reset_mid_clear");
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, NP + 3),
                 $urandom_range(0, 1), $urandom_range(0, NP + 3), $urandom_range(0, 7),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 9) == 0);
            checks++;
            if (obs_rdy !== m_rdy || err_oob !== m_err || clr_busy !== m_busy ||
                clr_done !== (m_done_c == cyc - 1)) begin
                errors++;
                $display("FAIL random cyc%0d got rdy%b err%b busy%b done%b want rdy%b err%b busy%b done%b",
                         cyc, obs_rdy, err_oob, clr_busy, clr_done,
                         m_rdy, m_err, m_busy, m_done_c == cyc - 1);
            end
        end
        for (int i = 0; i < 40 && m_busy; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NP; i++) tick(1, i, 0, 0, 0, 0, 0, 0);
        drain("random");
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset;
        test_write_read;
        test_disp_block;
        test_clear;
        test_clear_disp;
        test_oob;
        test_reset_mid_clear;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_bram_arbiter.md
# layer_bram_arbiter

Single-port access controller for the 320x240 3-bit layer frame buffer. It shares the one BRAM port among three sources. The display scan-out reader has absolute priority. A full-frame clear engine comes second, and the drawing writer comes last. The block sits between the layer BRAM and the VGA pipeline / drawing logic, and drives every BRAM address, write-enable and data-in.

## Interface
- NUM_PIX, 76800: frame size in pixels; valid addresses are 0..NUM_PIX-1
- ADDR_W, 19: address width
- DATA_W, 3: pixel width (RGB 1-bit each)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request this cycle (no ready; always accepted)
- disp_addr  in  ADDR_W  display read address
- disp_valid  out  1  registered; disp_data valid this cycle
- disp_data  out  DATA_W  registered read pixel
- wr_valid  in  1  draw write request
- wr_ready  out  1  combinational; draw write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_W  draw write address
- wr_data  in  DATA_W  draw write pixel
- clr_start  in  1  start full-frame clear (sampled only in IDLE)
- clr_color  in  DATA_W  fill colour, latched on clr_start
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse after the last clear write
- err_clr  in  1  clears err_oob
- err_oob  out  1  sticky; a draw write with wr_addr >= NUM_PIX was dropped
- mem_addr  out  ADDR_W  registered BRAM address
- mem_we  out  1  registered BRAM write enable
- mem_din  out  DATA_W  registered BRAM write data
- mem_dout  in  DATA_W  BRAM registered read data (1-cycle latency from mem_addr)

## Operation
- States: IDLE, CLEAR, DONE. Reset enters IDLE.
- Each cycle, exactly one source owns the port. Priority is display, then clear (state CLEAR), then draw (state IDLE).
- Display grant: mem_addr<=disp_addr, mem_we<=0. Out-of-range disp_addr still issues the read, but the returned disp_data is forced to 0.
- Draw grant: wr_ready = !disp_req && state==IDLE. On transfer, mem_addr<=wr_addr, mem_din<=wr_data, mem_we<=1. If wr_addr >= NUM_PIX, the transfer still completes but mem_we<=0 and err_oob<=1.
- Clear behaviour:
  - IDLE && clr_start: latch clr_color, set clr_cnt<=0 and clr_busy<=1, go to CLEAR.
  - In CLEAR, on each cycle without disp_req: mem_addr<=clr_cnt, mem_din<=colour, mem_we<=1, then clr_cnt++.
  - Writing clr_cnt==NUM_PIX-1 moves the state to DONE.
  - DONE lasts one cycle: clr_done=1, clr_busy=0, then IDLE.
- clr_start is ignored in CLEAR and DONE.
- Idle cycles (no grant): mem_we<=0, mem_addr and mem_din hold their values.
- err_oob: err_clr clears it. If err_clr and a new out-of-range write occur in the same cycle, the set wins.

## Timing
- Reset values: mem_addr=0, mem_we=0, mem_din=0, disp_valid=0, disp_data=0, clr_busy=0, clr_done=0, err_oob=0, state IDLE, clr_cnt=0.
- Display latency: disp_req is accepted at edge N, mem_addr is driven after N, the BRAM reads at N+1, and disp_valid/disp_data are registered at N+2. Throughput is one read per cycle with no bubbles.
- Draw write reaches the BRAM one edge after acceptance.
- A clear takes NUM_PIX write cycles plus one cycle per stolen display cycle. clr_done asserts the cycle after the final write issues.
- If clr_start and wr_valid arrive in the same IDLE cycle, the draw write is accepted and the clear begins next cycle.
- Reset mid-clear aborts the clear. Pixels already written stay written, and no clr_done is produced.
- wr_ready drops in the same cycle disp_req rises. A writer holding wr_valid must keep wr_addr/wr_data stable until the transfer.

## Test plan
- Reset, then write (addr 5, data 3'b010), then display-read addr 5 -> mem_we pulses once with mem_addr=5; disp_valid rises exactly 2 edges after the read is accepted, with disp_data=3'b010.
- disp_req held high while wr_valid=1 for 4 cycles -> wr_ready=0 throughout and no BRAM write; the write completes on the first cycle disp_req=0.
- NUM_PIX=16, clr_start with clr_color=3'b100 and no display traffic -> 16 consecutive writes to addr 0..15, clr_done pulses once, a readback of all 16 addresses returns 3'b100, and clr_busy is low afterwards.
- NUM_PIX=16 clear with disp_req asserted every third cycle -> clear writes pause on display cycles, no address is skipped or duplicated, and display reads still return data 2 cycles after acceptance.
- Draw write to addr NUM_PIX -> transfer completes, mem_we=0, err_oob=1; it stays set until err_clr, and err_clr in the same cycle as a new out-of-range write leaves err_oob=1.
- rst_n asserted at clear address 7 -> all outputs return to their reset values immediately, no clr_done pulse, and a new clr_start restarts the clear from address 0.
